// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus seen by mmio_uart_tx: one-cycle request, registered read response.
interface mmio_uart_tx_if;
    logic        mem_valid;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        sel;

    modport master (
        output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        input  mem_rdata, sel
    );

    modport slave (
        input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
        output mem_rdata, sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO console transmitter: DATA/STATUS registers, byte FIFO, 8N1 serializer on txd.
// Define MMIO_UART_EXIT_EN to decode the EXIT register at BASE+0x1000.
module mmio_uart_tx #(
    parameter logic [31:0] BASE         = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DEPTH_LOG2   = 4
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           exit_valid,
    output logic [7:0]     exit_code
);
    localparam int          DEPTH       = 2 ** DEPTH_LOG2;
    localparam logic [31:0] EXIT_ADDR   = BASE + 32'h0000_1000;
    localparam logic [29:0] DATA_WORD   = BASE[31:2];
    localparam logic [29:0] STATUS_WORD = DATA_WORD + 30'd1;
    localparam logic [29:0] EXIT_WORD   = EXIT_ADDR[31:2];
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    logic [29:0] word;
    logic        is_write, is_read, hit_data, hit_status, exit_mapped;
    logic        fifo_full, fifo_empty, baud_end, pop, push_req, push, busy;
    logic [31:0] status_word;
    logic        unused_bits;

    assign word        = bus.mem_addr[31:2];
    assign is_write    = bus.mem_valid & bus.mem_write;
    assign is_read     = bus.mem_valid & ~bus.mem_write;
    assign hit_data    = (word == DATA_WORD);
    assign hit_status  = (word == STATUS_WORD);
    assign fifo_full   = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign baud_end    = (baud_cnt == BAUD_LAST);
    // Popping on the last STOP cycle keeps back-to-back frames gapless.
    assign pop         = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_end));
    assign push_req    = is_write & hit_data & bus.mem_wmask[0];
    assign push        = push_req & (~fifo_full | pop);
    assign busy        = ~fifo_empty | (state != IDLE);
    assign status_word = {16'b0, 8'(count), 5'b0, overflow, fifo_full, busy};
    assign unused_bits = ^{bus.mem_wmask[3:1], bus.mem_wdata[31:8], bus.mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new overflow outranks the clear from a simultaneous STATUS read.
            if (push_req & ~push)
                overflow <= 1'b1;
            else if (is_read & hit_status)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        txd      <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        txd      <= shift[0];
                        shift    <= shift >> 1;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MMIO_UART_EXIT_EN
    logic hit_exit;
    assign hit_exit    = (word == EXIT_WORD);
    assign exit_mapped = hit_exit;

    always_ff @(posedge clk) begin
        if (rst) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else begin
            exit_valid <= is_write & hit_exit & bus.mem_wmask[0];
            if (is_write & hit_exit & bus.mem_wmask[0])
                exit_code <= bus.mem_wdata[7:0];
        end
    end
`else
    logic unused_exit;
    assign unused_exit = ^EXIT_WORD;
    assign exit_mapped = 1'b0;
    assign exit_valid  = 1'b0;
    assign exit_code   = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sel       <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.sel <= is_read & (hit_data | hit_status | exit_mapped);
            if (is_read & hit_status)
                bus.mem_rdata <= status_word;
            else if (is_read & exit_mapped)
                bus.mem_rdata <= {24'b0, exit_code};
            else
                bus.mem_rdata <= '0;
        end
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped console transmitter that sits on the Pipeline data-memory bus next to Memory32 and answers the CPU's MMIO writes in hardware. It accepts character writes at 0x10000000, buffers them in a FIFO and serializes them as 8N1 UART on `txd`. It exposes a readable status word, and optionally decodes the test-exit register at 0x10001000. It lets synthesized systems produce the console and exit behaviour that the simulation bench otherwise provides.

## Interface
- `BASE`, 32'h10000000, byte address of the DATA register; STATUS is at BASE+4, EXIT at BASE+0x1000.
- `CLKS_PER_BIT`, 434, clock cycles per UART bit; legal range 2..65535; 16-bit counter.
- `DEPTH_LOG2`, 4, FIFO depth = 2**DEPTH_LOG2 bytes.
- `clk  in  1`: single clock; all logic on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `mem_valid  in  1`: bus request this cycle.
- `mem_write  in  1`: 1 = write, 0 = read.
- `mem_wmask  in  4`: byte enables.
- `mem_wdata  in  32`: write data.
- `mem_addr  in  32`: full byte address; block decodes `mem_addr[31:2]`.
- `mem_rdata  out  32`: read data, registered.
- `sel  out  1`: registered; 1 when `mem_rdata` belongs to this block. Drives the system rdata mux.
- `txd  out  1`: UART line, idle high.
- `exit_valid  out  1`: one-cycle pulse on EXIT write.
- `exit_code  out  8`: last EXIT byte.

## Operation
- Register map:
  - DATA (BASE+0)
    - Write with `mem_wmask[0]` pushes `mem_wdata[7:0]`.
    - Write with `mem_wmask[0]=0` is ignored.
    - Read returns 0.
  - STATUS (BASE+4), read only. Writes are ignored. Fields:
    - bit0 busy: FIFO non-empty or serializer not IDLE.
    - bit1 full.
    - bit2 overflow: sticky.
    - bits[15:8] FIFO count, zero-extended.
    - Other bits 0.
    - A read clears overflow on the same edge it is sampled. If an overflow occurs on that same edge, overflow is left set.
- Unmapped addresses: never selected. `sel`=0, `mem_rdata`=0.
- The bus has no stall. Every access completes in one cycle.
- FIFO:
  - Circular buffer; pointers wrap modulo depth. Count is 0..2**DEPTH_LOG2.
  - A push when full with no pop that cycle is dropped and sets overflow.
  - Push and pop in the same cycle when full: the push is accepted, count is unchanged.
  - Push when empty: no bypass; the byte enters the FIFO first.
- Serializer FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if FIFO non-empty, pop into the shift register, load the bit counter, drive `txd`=0, go to START.
  - START, DATA, STOP each hold one bit for CLKS_PER_BIT cycles.
  - DATA shifts out 8 bits LSB first.
  - STOP drives 1. On its final cycle the FSM returns to IDLE; back-to-back frames follow with no extra idle bit.
- Reset:
  - Aborts any frame mid-operation and empties the FIFO.
  - Outputs after reset: `txd`=1, `sel`=0, `mem_rdata`=0, `exit_valid`=0, `exit_code`=0.
  - Overflow is cleared.

## Timing
- Read latency is 1 cycle: `sel` and `mem_rdata` are valid in the cycle after `mem_valid & !mem_write`, matching Memory32. Both return to 0 the following cycle unless another hit occurs.
- Write to DATA sampled at edge E0:
  - Byte is in the FIFO after E0.
  - With the serializer idle, it is popped at E1 and `txd` falls after E1.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- STATUS busy reflects state after the previous edge. It is 1 from the edge that stores the first byte until the last STOP cycle ends.
- `exit_valid` is high for exactly the one cycle after the EXIT write edge.

## Configuration
- `MMIO_UART_EXIT_EN` defined:
  - A write to BASE+0x1000 with `mem_wmask[0]` loads `exit_code` from `mem_wdata[7:0]` and pulses `exit_valid`.
  - `exit_code` holds its value until reset or the next EXIT write.
  - Reads of BASE+0x1000 return `{24'b0, exit_code}` with `sel`=1.
- Not defined:
  - BASE+0x1000 is unmapped.
  - `exit_valid` and `exit_code` are tied to 0.
  - Ports are kept so the instantiation is unchanged.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH_LOG2=4.
- **Single byte:** write 0x41 to DATA.
  - `txd` falls one cycle after the write.
  - 4-cycle bits: 0 | 1,0,0,0,0,0,1,0 | 1.
  - Then idle high; 40 cycles total.
- **Overflow:** 18 back-to-back DATA writes of 0x00..0x11.
  - 17 accepted: 1 in the shifter, 16 in the FIFO. 0x11 is dropped.
  - STATUS read returns 0x00001007.
  - A second STATUS read has bit2=0.
  - Exactly 17 frames are emitted, 0x00..0x10 in order.
- **Read path:**
  - Read STATUS when idle: next cycle `sel`=1, `mem_rdata`=0.
  - Read 0x10000008: `sel`=0, `mem_rdata`=0.
  - DATA write with `mem_wmask`=4'b0010: no push; count stays 0.
- **Full with simultaneous pop:** fill FIFO to 16, then push on the exact edge the serializer pops.
  - Count stays 16; overflow stays 0.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 5 bytes queued.
  - After the reset edge: `txd`=1, STATUS=0.
  - No further frames appear.
- **Exit (`MMIO_UART_EXIT_EN`):** write 0x00000003 to 0x10001000.
  - `exit_valid` is 1 for one cycle; `exit_code`=0x03.
  - Read-back returns 0x00000003.
  - Without the macro, `exit_valid` stays 0.
